pll_lock_sequencer: RTL
=======================

// Module: pll_lock_sequencer
// PURPOSE
//  Sequences bring-up of the 8x clock-multiplier PLL: holds PLL in reset, releases it,
//  waits for lock with timeout, enforces a settle window, then enables the downstream
//  clock gate. Retries failed lock attempts up to a limit. Sits in the always-on
//  ref-clock domain between system control and the PLL / clock-gate cell.
// PARAMETERS
//  RST_CYCLES     16    cycles pll_rst_n held low per attempt (>=1)
//  LOCK_TIMEOUT   1024  max cycles in WAIT_LOCK before attempt fails (>=1)
//  SETTLE_CYCLES  64    consecutive synced-lock cycles required before RUN (>=1)
//  MAX_RETRY      3     retries after first attempt before FAIL (0..15)
//  CNT_W          12    width of shared phase counter; must hold max of above counts
// PORTS
//  clk          in   1  ref clock; all logic posedge
//  RST          in   1  synchronous, active-high reset
//  start        in   1  pulse/level; begin bring-up (sampled in IDLE and FAIL only)
//  stop         in   1  abort; return to IDLE from any state; wins over start
//  pll_locked   in   1  PLL lock indication, asynchronous to clk
//  pll_rst_n    out  1  PLL reset, active-low, registered
//  clk_gate_en  out  1  enable for multiplied-clock gate, registered
//  ready        out  1  high only in RUN
//  fail         out  1  high only in FAIL (sticky until start/stop/RST)
//  retry_cnt    out  4  retries consumed in current bring-up
//  state        out  3  IDLE=0 RESET_PLL=1 WAIT_LOCK=2 SETTLE=3 RUN=4 FAIL=5
// BEHAVIOUR
//  - Reset (RST=1 at posedge): state=IDLE, pll_rst_n=0, clk_gate_en=0, ready=0, fail=0,
//    retry_cnt=0, counter=0, sync flops=0. RST mid-operation aborts immediately.
//  - pll_locked passes a 2-flop synchronizer -> locked_s (2-cycle latency); FSM uses locked_s only.
//  - All outputs registered, decoded from next state: change in the cycle state changes.
//  - IDLE: pll_rst_n=0. start=1 & stop=0 -> RESET_PLL next cycle, retry_cnt=0.
//  - RESET_PLL: pll_rst_n=0 for exactly RST_CYCLES cycles, then WAIT_LOCK, counter cleared.
//  - WAIT_LOCK: pll_rst_n=1. locked_s=1 -> SETTLE (counter cleared). Counter reaching
//    LOCK_TIMEOUT with locked_s=0 -> attempt fails. locked_s checked first on timeout cycle.
//  - SETTLE: locked_s must stay 1 for SETTLE_CYCLES consecutive cycles -> RUN.
//    locked_s=0 during SETTLE -> attempt fails.
//  - Attempt fail: retry_cnt<MAX_RETRY -> retry_cnt+1, RESET_PLL; else FAIL.
//    MAX_RETRY=0: first failure goes straight to FAIL.
//  - RUN: clk_gate_en=1, ready=1, pll_rst_n=1. locked_s=0 -> lock-loss handling (see CONFIG);
//    clk_gate_en drops in the same cycle state leaves RUN.
//  - FAIL: pll_rst_n=0, fail=1. start -> RESET_PLL with retry_cnt=0.
//  - stop=1 in any state -> IDLE next cycle, outputs to IDLE values; retry_cnt retained.
//  - start while busy (states 1-4) ignored. start & stop same cycle: stop wins.
//  - Counter saturates; never wraps. retry_cnt never exceeds MAX_RETRY.
// CONFIGURATION
//  PLL_AUTO_RELOCK_EN defined: lock loss in RUN -> RESET_PLL, retry_cnt cleared to 0
//    (fresh bring-up; full MAX_RETRY budget available).
//  PLL_AUTO_RELOCK_EN undefined: lock loss in RUN -> FAIL (fail=1, retry_cnt unchanged).
// TESTING
//  1. RST, start pulse, pll_locked rises 100 cycles after pll_rst_n=1 and holds ->
//     pll_rst_n low 16 cycles, SETTLE 64 cycles, RUN with ready=clk_gate_en=1, retry_cnt=0.
//  2. pll_locked tied 0 -> 4 attempts, each pll_rst_n low 16 cycles + 1024 wait cycles;
//     retry_cnt 0->3, then FAIL, fail=1, pll_rst_n=0.
//  3. pll_locked glitches low at SETTLE cycle 30 of first attempt -> retry_cnt=1,
//     RESET_PLL; lock held on second attempt -> RUN.
//  4. In RUN drop pll_locked: with PLL_AUTO_RELOCK_EN -> clk_gate_en=0, state=1,
//     retry_cnt=0; without -> state=5, fail=1.
//  5. start & stop asserted same cycle in IDLE -> remains IDLE; stop during WAIT_LOCK ->
//     IDLE next cycle, pll_rst_n=0.
//  6. RST asserted in SETTLE -> next cycle all outputs at reset values, state=0.

Source files
------------

// File: rtl/pll_lock_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pll_lock_sequencer
//  Description : Bring-up sequencer for the 8x clock-multiplier PLL. Holds the
//                PLL in reset, releases it, waits for lock with a timeout,
//                requires a settle window of continuous lock, then enables the
//                downstream clock gate. Failed attempts are retried up to
//                MAX_RETRY times before the sequencer parks in FAIL.
//                Lives in the always-on reference-clock domain.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   1  reference clock, all logic on posedge
//    RST          in   1  synchronous active-high reset
//    start        in   1  begin bring-up (honoured in IDLE and FAIL only)
//    stop         in   1  abort to IDLE from any state; wins over start
//    pll_locked   in   1  PLL lock indication, asynchronous to clk
//    pll_rst_n    out  1  PLL reset, active-low, registered
//    clk_gate_en  out  1  multiplied-clock gate enable, registered
//    ready        out  1  high only in RUN
//    fail         out  1  high only in FAIL
//    retry_cnt    out  4  retries consumed in the current bring-up
//    state        out  3  IDLE=0 RESET_PLL=1 WAIT_LOCK=2 SETTLE=3 RUN=4 FAIL=5
// ----------------------------------------------------------------------------
//  Build option
//    PLL_AUTO_RELOCK_EN : when defined, lock loss in RUN restarts bring-up in
//                         RESET_PLL with a fresh retry budget; when undefined,
//                         lock loss in RUN parks the sequencer in FAIL.
// ============================================================================
module pll_lock_sequencer #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 1024,
    parameter int SETTLE_CYCLES = 64,
    parameter int MAX_RETRY     = 3,
    parameter int CNT_W         = 12
) (
    input  logic       clk,
    input  logic       RST,
    input  logic       start,
    input  logic       stop,
    input  logic       pll_locked,
    output logic       pll_rst_n,
    output logic       clk_gate_en,
    output logic       ready,
    output logic       fail,
    output logic [3:0] retry_cnt,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RESET_PLL = 3'd1,
        S_WAIT_LOCK = 3'd2,
        S_SETTLE    = 3'd3,
        S_RUN       = 3'd4,
        S_FAIL      = 3'd5
    } state_t;

    // Terminal counts are "last cycle" values: the counter starts at zero on
    // state entry, so a phase lasting N cycles ends when the counter is N-1.
    localparam logic [CNT_W-1:0] c_RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CNT_ZERO    = '0;
    localparam logic [CNT_W-1:0] c_CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_CNT_MAX     = '1;
    localparam logic [3:0]       c_MAX_RETRY   = 4'(MAX_RETRY);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_retry;
    logic             r_sync1;
    logic             r_locked_s;
    logic             r_pll_rst_n;
    logic             r_clk_gate_en;
    logic             r_ready;
    logic             r_fail;

    state_t           w_next_state;
    logic [CNT_W-1:0] w_next_cnt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [3:0]       w_next_retry;
    logic             w_attempt_fail;

    // Phase counter saturates rather than wrapping.
    assign w_cnt_inc = (r_cnt == c_CNT_MAX) ? r_cnt : (r_cnt + c_CNT_ONE);

    // ------------------------------------------------------------------------
    // Next-state logic. Only the synchronised lock (r_locked_s) is used here.
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state   = r_state;
        w_next_cnt     = r_cnt;
        w_next_retry   = r_retry;
        w_attempt_fail = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_next_cnt = c_CNT_ZERO;
                if (start) begin
                    w_next_state = S_RESET_PLL;
                    w_next_retry = 4'd0;
                end
            end

            S_RESET_PLL: begin
                if (r_cnt >= c_RST_LAST) begin
                    w_next_state = S_WAIT_LOCK;
                    w_next_cnt   = c_CNT_ZERO;
                end else begin
                    w_next_cnt = w_cnt_inc;
                end
            end

            S_WAIT_LOCK: begin
                // Lock is checked before timeout, so lock arriving on the
                // final wait cycle still counts as success.
                if (r_locked_s) begin
                    w_next_state = S_SETTLE;
                    w_next_cnt   = c_CNT_ZERO;
                end else if (r_cnt >= c_LOCK_LAST) begin
                    w_attempt_fail = 1'b1;
                end else begin
                    w_next_cnt = w_cnt_inc;
                end
            end

            S_SETTLE: begin
                if (!r_locked_s) begin
                    w_attempt_fail = 1'b1;
                end else if (r_cnt >= c_SETTLE_LAST) begin
                    w_next_state = S_RUN;
                    w_next_cnt   = c_CNT_ZERO;
                end else begin
                    w_next_cnt = w_cnt_inc;
                end
            end

            S_RUN: begin
                w_next_cnt = c_CNT_ZERO;
                if (!r_locked_s) begin
`ifdef PLL_AUTO_RELOCK_EN
                    // Lock loss starts a fresh bring-up with a full budget.
                    w_next_state = S_RESET_PLL;
                    w_next_retry = 4'd0;
`else
                    w_next_state = S_FAIL;
`endif
                end
            end

            S_FAIL: begin
                w_next_cnt = c_CNT_ZERO;
                if (start) begin
                    w_next_state = S_RESET_PLL;
                    w_next_retry = 4'd0;
                end
            end

            default: begin
                w_next_state = S_IDLE;
                w_next_cnt   = c_CNT_ZERO;
            end
        endcase

        // Shared handling for a failed lock or settle attempt.
        if (w_attempt_fail) begin
            w_next_cnt = c_CNT_ZERO;
            if (r_retry < c_MAX_RETRY) begin
                w_next_retry = r_retry + 4'd1;
                w_next_state = S_RESET_PLL;
            end else begin
                w_next_state = S_FAIL;
            end
        end

        // Abort overrides everything; the retry count is kept for diagnosis.
        if (stop) begin
            w_next_state = S_IDLE;
            w_next_cnt   = c_CNT_ZERO;
            w_next_retry = r_retry;
        end
    end

    // ------------------------------------------------------------------------
    // State, counter, synchroniser and outputs. Outputs are decoded from the
    // next state so they change in the same cycle as the state register.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (RST) begin
            r_state       <= S_IDLE;
            r_cnt         <= c_CNT_ZERO;
            r_retry       <= 4'd0;
            r_sync1       <= 1'b0;
            r_locked_s    <= 1'b0;
            r_pll_rst_n   <= 1'b0;
            r_clk_gate_en <= 1'b0;
            r_ready       <= 1'b0;
            r_fail        <= 1'b0;
        end else begin
            r_sync1       <= pll_locked;
            r_locked_s    <= r_sync1;
            r_state       <= w_next_state;
            r_cnt         <= w_next_cnt;
            r_retry       <= w_next_retry;
            r_pll_rst_n   <= (w_next_state == S_WAIT_LOCK) ||
                             (w_next_state == S_SETTLE)    ||
                             (w_next_state == S_RUN);
            r_clk_gate_en <= (w_next_state == S_RUN);
            r_ready       <= (w_next_state == S_RUN);
            r_fail        <= (w_next_state == S_FAIL);
        end
    end

    assign pll_rst_n   = r_pll_rst_n;
    assign clk_gate_en = r_clk_gate_en;
    assign ready       = r_ready;
    assign fail        = r_fail;
    assign retry_cnt   = r_retry;
    assign state       = r_state;

endmodule
`default_nettype wire
